// File: rtl/fpu_issue_ctrl_if.sv
// Request, fpu-side and response-side signal bundle for fpu_issue_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
`timescale 1ns/1ps
interface fpu_issue_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [15:0] req_opA_i;
  logic [15:0] req_opB_i;
  logic [1:0]  req_op_i;
  logic [1:0]  req_status_i;
  logic [15:0] fpu_opA_o;
  logic [15:0] fpu_opB_o;
  logic [1:0]  fpu_op_o;
  logic [1:0]  fpu_status_o;
  logic [15:0] fpu_result_i;
  logic [1:0]  fpu_status_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [15:0] rsp_result_o;
  logic [1:0]  rsp_status_o;
  logic        idle_o;
  logic [15:0] perf_stall_o;

  modport slave (
    input  req_valid_i, req_opA_i, req_opB_i, req_op_i, req_status_i,
    input  fpu_result_i, fpu_status_i, rsp_ready_i,
    output req_ready_o, fpu_opA_o, fpu_opB_o, fpu_op_o, fpu_status_o,
    output rsp_valid_o, rsp_result_o, rsp_status_o, idle_o, perf_stall_o
  );

  modport master (
    output req_valid_i, req_opA_i, req_opB_i, req_op_i, req_status_i,
    output fpu_result_i, fpu_status_i, rsp_ready_i,
    input  req_ready_o, fpu_opA_o, fpu_opB_o, fpu_op_o, fpu_status_o,
    input  rsp_valid_o, rsp_result_o, rsp_status_o, idle_o, perf_stall_o
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue/credit front end and result FIFO back end for a fixed-latency, non-stalling fpu.
// Define FPU_ISSUE_PERF_EN to build the saturating stall counter on perf_stall_o.
`timescale 1ns/1ps
module fpu_issue_ctrl #(
  parameter int PIPELINE_DEPTH    = 3,
  parameter int RESULT_FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  fpu_issue_ctrl_if.slave io
);
  localparam int CW = $clog2(RESULT_FIFO_DEPTH + 1);
  localparam int AW = (RESULT_FIFO_DEPTH > 1) ? $clog2(RESULT_FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CRED_INIT = CW'(RESULT_FIFO_DEPTH);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [AW-1:0] LAST      = AW'(RESULT_FIFO_DEPTH - 1);

  logic [CW-1:0] credits;
  logic [CW-1:0] inflight;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [17:0]   mem [RESULT_FIFO_DEPTH];
  logic          accept;
  logic          issue;
  logic          push;
  logic          pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  assign accept = io.req_valid_i && io.req_ready_o;
  assign issue  = accept && (io.req_status_i != 2'b00);
  // A result with nothing in flight is a leftover from before a reset.
  assign push   = (io.fpu_status_i != 2'b00) && (inflight != '0);
  assign pop    = io.rsp_valid_o && io.rsp_ready_i;

  assign io.req_ready_o  = (credits != '0);
  assign io.rsp_valid_o  = (count != '0);
  assign {io.rsp_status_o, io.rsp_result_o} = mem[rd_ptr];
  assign io.idle_o       = (inflight == '0) && (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io.fpu_opA_o    <= 16'h0;
      io.fpu_opB_o    <= 16'h0;
      io.fpu_op_o     <= 2'b00;
      io.fpu_status_o <= 2'b00;
      credits         <= CRED_INIT;
      inflight        <= '0;
      count           <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
    end else begin
      if (issue) begin
        io.fpu_opA_o    <= io.req_opA_i;
        io.fpu_opB_o    <= io.req_opB_i;
        io.fpu_op_o     <= io.req_op_i;
        io.fpu_status_o <= io.req_status_i;
      end else begin
        io.fpu_status_o <= 2'b00;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({issue, pop})
        2'b10:   credits <= credits - ONE;
        2'b01:   credits <= credits + ONE;
        default: ;
      endcase
      case ({issue, push})
        2'b10:   inflight <= inflight + ONE;
        2'b01:   inflight <= inflight - ONE;
        default: ;
      endcase
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {io.fpu_status_i, io.fpu_result_i};
  end

`ifdef FPU_ISSUE_PERF_EN
  logic [15:0] stall_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'h0;
    end else if (io.req_valid_i && !io.req_ready_o && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
  assign io.perf_stall_o = stall_cnt;
`else
  assign io.perf_stall_o = 16'h0;
`endif

`ifndef SYNTHESIS
  // Credits reserve a slot per issued op, so the FIFO can never overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && (count == CRED_INIT) && !pop));
      assert ((int'(credits) + int'(inflight) + int'(count)) == RESULT_FIFO_DEPTH);
      assert (int'(inflight) <= PIPELINE_DEPTH + 1);
    end
  end
`endif
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a 3-stage fpu stand-in and a response scoreboard.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;
  localparam int PD = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fpu_issue_ctrl_if ifc();

  fpu_issue_ctrl #(.PIPELINE_DEPTH(PD), .RESULT_FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .io(ifc.slave)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [17:0] sb[$];
  logic [17:0] exp_e;

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    if (h[14:10] == 5'd0) return 0.0;
    v = 1.0 + real'(int'(h[9:0])) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real        a;
    int         e;
    logic [9:0] m;
    logic [4:0] ef;
    if (r == 0.0) return 16'h0;
    a = (r < 0.0) ? -r : r;
    e = 15;
    for (int i = 0; i < 40 && a >= 2.0; i++) begin a = a / 2.0; e++; end
    for (int j = 0; j < 40 && a < 1.0; j++) begin a = a * 2.0; e--; end
    m  = 10'(int'((a - 1.0) * 1024.0));
    ef = 5'(e);
    return {(r < 0.0), ef, m};
  endfunction

  function automatic logic [15:0] fpu_calc(input logic [1:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    case (op)
      2'd0:    return r2h(h2r(a) + h2r(b));
      2'd1:    return r2h(h2r(a) - h2r(b));
      2'd2:    return r2h(h2r(a) * h2r(b));
      default: return (h2r(b) == 0.0) ? 16'h7C00 : r2h(h2r(a) / h2r(b));
    endcase
  endfunction

  // fpu stand-in: fixed latency, no reset, so ops in flight at reset still emerge
  logic [15:0] s1_res = 16'h0, s2_res = 16'h0, s3_res = 16'h0;
  logic [1:0]  s1_tag = 2'b0,  s2_tag = 2'b0,  s3_tag = 2'b0;
  always @(posedge clk) begin
    s1_res <= (ifc.fpu_status_o != 2'b0) ?
              fpu_calc(ifc.fpu_op_o, ifc.fpu_opA_o, ifc.fpu_opB_o) : 16'h0;
    s1_tag <= ifc.fpu_status_o;
    s2_res <= s1_res;  s2_tag <= s1_tag;
    s3_res <= s2_res;  s3_tag <= s2_tag;
  end
  assign ifc.fpu_result_i = s3_res;
  assign ifc.fpu_status_i = s3_tag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && ifc.rsp_valid_o && ifc.rsp_ready_i) begin
      if (sb.size() == 0) begin
        n_checks++;
        $error("FAIL rsp_unexpected: observed %0h expected no response",
               {ifc.rsp_status_o, ifc.rsp_result_o});
      end else begin
        exp_e = sb.pop_front();
        check("rsp_entry", {14'b0, ifc.rsp_status_o, ifc.rsp_result_o}, {14'b0, exp_e});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] tag);
    int w;
    w = 0;
    ifc.req_valid_i  = 1'b1;
    ifc.req_op_i     = op;
    ifc.req_opA_i    = a;
    ifc.req_opB_i    = b;
    ifc.req_status_i = tag;
    @(negedge clk);
    while (!ifc.req_ready_o && w < 100) begin
      @(posedge clk); #1;
      @(negedge clk);
      w++;
    end
    check("req_accept", {31'b0, ifc.req_ready_o}, 32'd1);
    if (ifc.req_ready_o && tag != 2'b0) sb.push_back({tag, fpu_calc(op, a, b)});
    @(posedge clk); #1;
    ifc.req_valid_i = 1'b0;
    check("fpu_issue_tag", {30'b0, ifc.fpu_status_o}, {30'b0, tag});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    ifc.req_valid_i  = 1'b0;
    ifc.req_opA_i    = 16'h0;
    ifc.req_opB_i    = 16'h0;
    ifc.req_op_i     = 2'b0;
    ifc.req_status_i = 2'b0;
    ifc.rsp_ready_i  = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'b0, ifc.req_ready_o}, 32'd1);
    check("rst_rsp_valid", {31'b0, ifc.rsp_valid_o}, 32'd0);
    check("rst_idle", {31'b0, ifc.idle_o}, 32'd1);
    check("rst_fpu_status", {30'b0, ifc.fpu_status_o}, 32'd0);
    check("rst_fpu_opA", {16'b0, ifc.fpu_opA_o}, 32'd0);
    check("rst_perf", {16'b0, ifc.perf_stall_o}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1);

    // single ADD: 1.0 + 2.0 = 3.0, response PD+1 edges after acceptance
    send(2'd0, 16'h3C00, 16'h4000, 2'd1);
    for (int i = 0; i < PD + 1; i++) begin
      @(negedge clk);
      check("lat_early_valid", {31'b0, ifc.rsp_valid_o}, 32'd0);
      if (i == 0) check("busy_idle", {31'b0, ifc.idle_o}, 32'd0);
    end
    @(negedge clk);
    check("lat_valid", {31'b0, ifc.rsp_valid_o}, 32'd1);
    check("add_result", {16'b0, ifc.rsp_result_o}, 32'h4200);
    check("add_tag", {30'b0, ifc.rsp_status_o}, 32'd1);
    cyc(2);
    check("idle_after_single", {31'b0, ifc.idle_o}, 32'd1);

    // four back-to-back MULs drain on consecutive cycles
    send(2'd2, 16'h3C00, 16'h4000, 2'd1);
    send(2'd2, 16'h4000, 16'h4000, 2'd2);
    send(2'd2, 16'h4200, 16'h4000, 2'd3);
    send(2'd2, 16'h3800, 16'h4400, 2'd1);
    w = 0;
    @(negedge clk);
    while (!ifc.rsp_valid_o && w < 20) begin @(negedge clk); w++; end
    check("b2b_first_valid", {31'b0, ifc.rsp_valid_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b_consecutive", {31'b0, ifc.rsp_valid_o}, 32'd1);
    end
    @(negedge clk);
    check("b2b_end", {31'b0, ifc.rsp_valid_o}, 32'd0);

    // tag 0 is swallowed: no issue, no response, no credit used
    send(2'd1, 16'h4000, 16'h3C00, 2'd0);
    for (int i = 0; i < PD + 3; i++) begin
      @(negedge clk);
      check("tag0_no_rsp", {31'b0, ifc.rsp_valid_o}, 32'd0);
    end
    check("tag0_credits", 32'(dut.credits), 32'd4);
    check("tag0_idle", {31'b0, ifc.idle_o}, 32'd1);

    // reset two cycles after issue; the stray result must be dropped
    send(2'd0, 16'h3C00, 16'h3C00, 2'd2);
    cyc(2);
    reset = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_req_ready", {31'b0, ifc.req_ready_o}, 32'd1);
    check("mid_rst_fpu_status", {30'b0, ifc.fpu_status_o}, 32'd0);
    check("mid_rst_fpu_opA", {16'b0, ifc.fpu_opA_o}, 32'd0);
    check("mid_rst_fpu_opB", {16'b0, ifc.fpu_opB_o}, 32'd0);
    check("mid_rst_rsp_valid", {31'b0, ifc.rsp_valid_o}, 32'd0);
    check("mid_rst_idle", {31'b0, ifc.idle_o}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < PD + 2; i++) begin
      @(negedge clk);
      check("stray_dropped", {31'b0, ifc.rsp_valid_o}, 32'd0);
    end
    check("stray_idle", {31'b0, ifc.idle_o}, 32'd1);
    check("stray_perf", {16'b0, ifc.perf_stall_o}, 32'd0);
    cyc(1);

    // back-pressure: 4 credits fill, fifth request stalls for 5 cycles
    ifc.rsp_ready_i = 1'b0;
    send(2'd0, 16'h4000, 16'h4000, 2'd1);
    send(2'd1, 16'h4400, 16'h3C00, 2'd2);
    send(2'd3, 16'h4400, 16'h4000, 2'd3);
    send(2'd2, 16'h3800, 16'h3800, 2'd1);
    ifc.req_valid_i  = 1'b1;
    ifc.req_op_i     = 2'd3;
    ifc.req_opA_i    = 16'h3C00;
    ifc.req_opB_i    = 16'h4000;
    ifc.req_status_i = 2'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_not_ready", {31'b0, ifc.req_ready_o}, 32'd0);
      @(posedge clk); #1;
    end
    ifc.req_valid_i = 1'b0;
    check("bp_rsp_valid", {31'b0, ifc.rsp_valid_o}, 32'd1);
`ifdef FPU_ISSUE_PERF_EN
    check("perf_stall", {16'b0, ifc.perf_stall_o}, 32'd5);
`else
    check("perf_stall", {16'b0, ifc.perf_stall_o}, 32'd0);
`endif
    ifc.rsp_ready_i = 1'b1;
    send(2'd3, 16'h3C00, 16'h4000, 2'd2);
    send(2'd0, 16'h3800, 16'h3800, 2'd3);
    w = 0;
    while (sb.size() != 0 && w < 40) begin cyc(1); w++; end
    check("bp_all_drained", 32'(sb.size()), 32'd0);
    cyc(2);
    check("final_idle", {31'b0, ifc.idle_o}, 32'd1);
    check("final_credits", 32'(dut.credits), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
